ex_muldiv_ctrl: RTL and testbench

//  Multi-cycle sequencer for RV64M multiply/divide in EX. Accepts the op held in EX and

---
 rtl/ex_muldiv_ctrl.sv | 93 +++++++++
 tb/tb_ex_muldiv_ctrl.sv | 126 ++++++++++++
 2 files changed

// File: rtl/ex_muldiv_ctrl.sv
// ex_muldiv_ctrl: multi-cycle RV64M sequencer (radix-2 shift-add multiply / restoring divide)
// that stalls IF/ID/EX while it iterates and pulses md_valid_EX with the sign-corrected result.
module ex_muldiv_ctrl #(
    parameter int XLEN = 64
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_md_start_EX,
    input  logic [2:0]      i_funct3_EX,
    input  logic [XLEN-1:0] i_rs1_data_EX,
    input  logic [XLEN-1:0] i_rs2_data_EX,
    input  logic            i_flush_EX,
    output logic            o_stall_EX,
    output logic            o_md_valid_EX,
    output logic [XLEN-1:0] o_result_EX,
    output logic            o_md_busy
);
    localparam int CW = $clog2(XLEN);
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;
    state_t              r_state, w_next;
    logic [CW-1:0]       r_count;
    logic [2:0]          r_f3;
    logic                r_sa, r_sb;
    logic [XLEN-1:0]     r_b, r_result;
    logic [2*XLEN-1:0]   r_acc;
    logic                w_accept, w_a_signed, w_b_signed, w_sa, w_sb, w_div0, w_ovf, w_last, w_ok;
    logic [XLEN-1:0]     w_abs_a, w_abs_b, w_special, w_quo, w_rem, w_fin;
    logic [XLEN:0]       w_mul_sum, w_trial;
    logic [2*XLEN-1:0]   w_mul_nxt, w_div_nxt, w_nxt, w_prod;
    assign w_accept   = (r_state == S_IDLE) && i_md_start_EX && !i_flush_EX;
    assign w_a_signed = !(i_funct3_EX inside {3'b011, 3'b101, 3'b111});
    assign w_b_signed = !(i_funct3_EX inside {3'b010, 3'b011, 3'b101, 3'b111});
    assign w_sa       = w_a_signed && i_rs1_data_EX[XLEN-1];
    assign w_sb       = w_b_signed && i_rs2_data_EX[XLEN-1];
    assign w_abs_a    = w_sa ? -i_rs1_data_EX : i_rs1_data_EX;
    assign w_abs_b    = w_sb ? -i_rs2_data_EX : i_rs2_data_EX;
    assign w_div0     = i_rs2_data_EX == '0;
    assign w_ovf      = !i_funct3_EX[0] && (i_rs1_data_EX == {1'b1, {(XLEN-1){1'b0}}}) && (i_rs2_data_EX == '1);
    assign w_special  = w_div0 ? (i_funct3_EX[1] ? i_rs1_data_EX : '1) : (i_funct3_EX[1] ? '0 : i_rs1_data_EX);
    // Multiply: accumulator upper half gathers partial products, lower half holds the multiplier.
    assign w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_b} : '0);
    assign w_mul_nxt  = {w_mul_sum, r_acc[XLEN-1:1]};
    // Divide: accumulator is remainder:quotient; the remainder stays below the divisor.
    assign w_trial    = r_acc[2*XLEN-1:XLEN-1] - {1'b0, r_b};
    assign w_ok       = !w_trial[XLEN];
    assign w_div_nxt  = w_ok ? {w_trial[XLEN-1:0], r_acc[XLEN-2:0], 1'b1} : {r_acc[2*XLEN-2:0], 1'b0};
    assign w_nxt      = (r_state == S_MUL) ? w_mul_nxt : w_div_nxt;
    assign w_prod     = (r_sa ^ r_sb) ? -w_nxt : w_nxt;
    assign w_quo      = (r_sa ^ r_sb) ? -w_nxt[XLEN-1:0] : w_nxt[XLEN-1:0];
    assign w_rem      = r_sa ? -w_nxt[2*XLEN-1:XLEN] : w_nxt[2*XLEN-1:XLEN];
    assign w_fin      = (r_state == S_MUL) ? ((r_f3 == 3'b000) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN])
                                           : (r_f3[1] ? w_rem : w_quo);
    assign w_last     = r_count == CW'(XLEN-1);
    assign o_stall_EX    = w_accept || (((r_state == S_MUL) || (r_state == S_DIV)) && !i_flush_EX);
    assign o_md_valid_EX = (r_state == S_DONE) && !i_flush_EX;
    assign o_md_busy     = r_state != S_IDLE;
    assign o_result_EX   = r_result;
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:       if (w_accept) w_next = !i_funct3_EX[2] ? S_MUL : (w_div0 || w_ovf) ? S_DONE : S_DIV;
            S_MUL, S_DIV: w_next = i_flush_EX ? S_IDLE : w_last ? S_DONE : r_state;
            default:      w_next = S_IDLE;
        endcase
    end
    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= S_IDLE;
        else         r_state <= w_next;
    end
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_count  <= '0;
            r_f3     <= '0;
            r_sa     <= 1'b0;
            r_sb     <= 1'b0;
            r_b      <= '0;
            r_acc    <= '0;
            r_result <= '0;
        end else if (w_accept) begin
            r_count  <= '0;
            r_f3     <= i_funct3_EX;
            r_sa     <= w_sa;
            r_sb     <= w_sb;
            r_b      <= w_abs_b;
            r_acc    <= {{XLEN{1'b0}}, w_abs_a};
            if (i_funct3_EX[2] && (w_div0 || w_ovf)) r_result <= w_special;
        end else if (((r_state == S_MUL) || (r_state == S_DIV)) && !i_flush_EX) begin
            r_count  <= r_count + 1'b1;
            r_acc    <= w_nxt;
            if (w_last) r_result <= w_fin;
        end
    end
endmodule

// File: tb/tb_ex_muldiv_ctrl.sv
// tb_ex_muldiv_ctrl: directed checks of ex_muldiv_ctrl results, latency, stall window,
// special divide cases, flush and mid-operation reset.
module tb_ex_muldiv_ctrl;
    logic        clk = 1'b0;
    logic        reset, start, flush;
    logic [2:0]  f3;
    logic [63:0] rs1, rs2;
    logic        stall, valid, busy;
    logic [63:0] result;
    int          errors = 0;
    int          checks = 0;

    ex_muldiv_ctrl #(.XLEN(64)) dut (
        .i_clk(clk), .i_reset(reset), .i_md_start_EX(start), .i_funct3_EX(f3),
        .i_rs1_data_EX(rs1), .i_rs2_data_EX(rs2), .i_flush_EX(flush),
        .o_stall_EX(stall), .o_md_valid_EX(valid), .o_result_EX(result), .o_md_busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] f, input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] exp, input int lat);
        int n = 0;
        int sc;
        @(posedge clk); #2;
        start = 1'b1; f3 = f; rs1 = a; rs2 = b;
        #1;
        sc = stall ? 1 : 0;
        do begin
            @(posedge clk); #2;
            n++;
            if (n == 1) begin
                rs1 = {$urandom, $urandom};
                rs2 = {$urandom, $urandom};
            end
            if (stall) sc++;
        end while (!valid && n < 200);
        chk({tag, " latency"}, 64'(n), 64'(lat));
        chk({tag, " stall cycles"}, 64'(sc), 64'(lat));
        chk({tag, " result"}, result, exp);
        @(posedge clk); #2;
        chk({tag, " valid pulse"}, {63'd0, valid}, 64'd0);
        chk({tag, " busy after done"}, {63'd0, busy}, 64'd0);
        chk({tag, " result hold"}, result, exp);
        start = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; flush = 1'b0; f3 = 3'b000; rs1 = '0; rs2 = '0;
        repeat (2) @(posedge clk);
        #2;
        chk("reset stall", {63'd0, stall}, 64'd0);
        chk("reset valid", {63'd0, valid}, 64'd0);
        chk("reset busy", {63'd0, busy}, 64'd0);
        chk("reset result", result, 64'd0);
        reset = 1'b0;

        run_op("MULHU", 3'b011, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd1, 65);
        run_op("MULHSU", 3'b010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65);
        run_op("MUL", 3'b000, -64'sd3, 64'd7, 64'hFFFF_FFFF_FFFF_FFEB, 65);
        run_op("DIV", 3'b100, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65);
        run_op("REM", 3'b110, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65);
        run_op("DIVU", 3'b101, 64'd100, 64'd7, 64'd14, 65);
        run_op("REMU", 3'b111, 64'd100, 64'd7, 64'd2, 65);
        run_op("DIVU by zero", 3'b101, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
        run_op("REM by zero", 3'b110, 64'd5, 64'd0, 64'd5, 1);
        run_op("DIV overflow", 3'b100, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1);
        run_op("REM overflow", 3'b110, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1);

        // flush while in IDLE blocks acceptance
        @(posedge clk); #2;
        start = 1'b1; flush = 1'b1; f3 = 3'b101; rs1 = 64'd9; rs2 = 64'd3;
        #1;
        chk("idle flush stall", {63'd0, stall}, 64'd0);
        @(posedge clk); #2;
        start = 1'b0; flush = 1'b0;
        chk("idle flush busy", {63'd0, busy}, 64'd0);

        // flush at cycle 20 of a DIV
        @(posedge clk); #2;
        start = 1'b1; f3 = 3'b101; rs1 = 64'd100; rs2 = 64'd7;
        repeat (20) @(posedge clk);
        #2;
        chk("div busy before flush", {63'd0, busy}, 64'd1);
        flush = 1'b1; start = 1'b0;
        #1;
        chk("flush stall same cycle", {63'd0, stall}, 64'd0);
        chk("flush valid", {63'd0, valid}, 64'd0);
        @(posedge clk); #2;
        flush = 1'b0;
        chk("post flush busy", {63'd0, busy}, 64'd0);
        chk("post flush valid", {63'd0, valid}, 64'd0);
        chk("post flush stall", {63'd0, stall}, 64'd0);
        chk("post flush result held", result, 64'd0);
        run_op("MUL after flush", 3'b000, 64'd12345, 64'd1000, 64'd12345000, 65);

        // reset mid-MUL
        @(posedge clk); #2;
        start = 1'b1; f3 = 3'b000; rs1 = 64'd6; rs2 = 64'd7;
        repeat (30) @(posedge clk);
        #2;
        chk("mul busy before reset", {63'd0, busy}, 64'd1);
        reset = 1'b1; start = 1'b0;
        @(posedge clk); #2;
        chk("mid reset stall", {63'd0, stall}, 64'd0);
        chk("mid reset valid", {63'd0, valid}, 64'd0);
        chk("mid reset busy", {63'd0, busy}, 64'd0);
        chk("mid reset result", result, 64'd0);
        start = 1'b1;
        @(posedge clk); #2;
        chk("reset beats start", {63'd0, busy}, 64'd0);
        reset = 1'b0; start = 1'b0;
        run_op("MULH after reset", 3'b001, -64'sd3, 64'd7, 64'hFFFF_FFFF_FFFF_FFFF, 65);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
